// File: rtl/ws_tile_controller.sv
`default_nettype none
// ============================================================================
// Module   : ws_tile_controller
// Brief    : Weight-stationary tile sequencer: per-tile weight load, then
//            skewed per-column iact and per-row psum strobes with stall support.
// Revision : 1.0
// ============================================================================
module ws_tile_controller #(
    parameter int ARRAY_ROWS = 3,
    parameter int ARRAY_COLS = 3,
    parameter int ADDR_W     = 32,
    parameter int VEC_W      = 16,
    parameter int TILE_W     = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                go,
    input  logic [VEC_W-1:0]                    n_vec,
    input  logic [TILE_W-1:0]                   n_tiles,
    input  logic [ADDR_W-1:0]                   w_base,
    input  logic [ADDR_W-1:0]                   w_stride,
    input  logic [ADDR_W-1:0]                   iact_base,
    input  logic [ADDR_W-1:0]                   iact_col_stride,
    input  logic [ADDR_W-1:0]                   psum_base,
    input  logic [ADDR_W-1:0]                   psum_row_stride,
    input  logic                                mem_ready,
    output logic [ADDR_W-1:0]                   weight_addr,
    output logic [ARRAY_COLS-1:0][ADDR_W-1:0]   iact_addr,
    output logic [ARRAY_ROWS-1:0][ADDR_W-1:0]   psum_addr,
    output logic                                load_weight,
    output logic [ARRAY_COLS-1:0]               load_iact,
    output logic [ARRAY_ROWS-1:0]               psum_valid,
    output logic                                busy,
    output logic                                done
);

    localparam int c_KW = VEC_W + 1;
    localparam int c_BW = (ARRAY_COLS > 1) ? $clog2(ARRAY_COLS) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_NEXT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]                             r_state;
    logic [2:0]                             w_next_state;
    logic [VEC_W-1:0]                       r_n_vec;
    logic [TILE_W-1:0]                      r_n_tiles;
    logic [TILE_W-1:0]                      r_tile;
    logic [ADDR_W-1:0]                      r_w_stride;
    logic [c_BW-1:0]                        r_beat;
    logic [c_KW-1:0]                        r_k;
    logic [ADDR_W-1:0]                      r_weight_addr;
    logic [ARRAY_COLS-1:0][ADDR_W-1:0]      r_iact_start;
    logic [ARRAY_COLS-1:0][ADDR_W-1:0]      r_iact_addr;
    logic [ARRAY_ROWS-1:0][ADDR_W-1:0]      r_psum_addr;

    logic [c_KW-1:0]                        w_nvec_ext;
    logic [ARRAY_COLS-1:0]                  w_iact_win;
    logic [ARRAY_ROWS-1:0]                  w_psum_win;
    logic                                   w_k_last;
    logic                                   w_beat_last;
    logic [TILE_W-1:0]                      w_tile_inc;
    logic                                   w_cfg_empty;

    assign w_nvec_ext  = {1'b0, r_n_vec};
    assign w_k_last    = (r_k == w_nvec_ext + c_KW'(ARRAY_ROWS + ARRAY_COLS - 2));
    assign w_beat_last = (r_beat == c_BW'(ARRAY_COLS - 1));
    assign w_tile_inc  = r_tile + TILE_W'(1);
    assign w_cfg_empty = (n_vec == '0) || (n_tiles == '0);

    // Column c sees iact vectors during k in [c, c+n_vec): the systolic skew.
    for (genvar c = 0; c < ARRAY_COLS; c++) begin : g_col
        assign w_iact_win[c] = (r_k >= c_KW'(c)) && (r_k < c_KW'(c) + w_nvec_ext);
    end

    for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
        assign w_psum_win[r] = (r_k >= c_KW'(r + ARRAY_COLS)) &&
                               (r_k < c_KW'(r + ARRAY_COLS) + w_nvec_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        load_weight  = 1'b0;
        load_iact    = '0;
        psum_valid   = '0;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_next_state = w_cfg_empty ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                load_weight = mem_ready;
                if (mem_ready && w_beat_last) begin
                    w_next_state = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                load_iact  = mem_ready ? w_iact_win : '0;
                psum_valid = mem_ready ? w_psum_win : '0;
                if (mem_ready && w_k_last) begin
                    w_next_state = S_NEXT;
                end
            end
            S_NEXT: begin
                w_next_state = (w_tile_inc == r_n_tiles) ? S_DONE : S_LOAD_W;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_vec       <= '0;
            r_n_tiles     <= '0;
            r_tile        <= '0;
            r_w_stride    <= '0;
            r_beat        <= '0;
            r_k           <= '0;
            r_weight_addr <= '0;
            r_iact_start  <= '0;
            r_iact_addr   <= '0;
            r_psum_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_n_vec    <= n_vec;
                        r_n_tiles  <= n_tiles;
                        r_w_stride <= w_stride;
                        r_tile     <= '0;
                        r_beat     <= '0;
                        r_k        <= '0;
                        // An empty run leaves the previous addresses visible.
                        if (!w_cfg_empty) begin
                            r_weight_addr <= w_base;
                            for (int c = 0; c < ARRAY_COLS; c++) begin
                                r_iact_start[c] <= iact_base + ADDR_W'(c) * iact_col_stride;
                                r_iact_addr[c]  <= iact_base + ADDR_W'(c) * iact_col_stride;
                            end
                            for (int r = 0; r < ARRAY_ROWS; r++) begin
                                r_psum_addr[r] <= psum_base + ADDR_W'(r) * psum_row_stride;
                            end
                        end
                    end
                end
                S_LOAD_W: begin
                    if (mem_ready) begin
                        r_weight_addr <= r_weight_addr + r_w_stride;
                        r_beat        <= w_beat_last ? '0 : r_beat + c_BW'(1);
                        r_k           <= '0;
                    end
                end
                S_COMPUTE: begin
                    if (mem_ready) begin
                        r_k <= r_k + c_KW'(1);
                        for (int c = 0; c < ARRAY_COLS; c++) begin
                            if (load_iact[c]) r_iact_addr[c] <= r_iact_addr[c] + ADDR_W'(1);
                        end
                        for (int r = 0; r < ARRAY_ROWS; r++) begin
                            if (psum_valid[r]) r_psum_addr[r] <= r_psum_addr[r] + ADDR_W'(1);
                        end
                    end
                end
                S_NEXT: begin
                    r_tile      <= w_tile_inc;
                    r_iact_addr <= r_iact_start;
                end
                default: begin
                end
            endcase
        end
    end

    assign weight_addr = r_weight_addr;
    assign iact_addr   = r_iact_addr;
    assign psum_addr   = r_psum_addr;

endmodule
`default_nettype wire

// File: tb/tb_ws_tile_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws_tile_controller
// Brief    : Table-driven bench with a transaction scoreboard for ws_tile_controller.
// Revision : 1.0
// ============================================================================
module tb_ws_tile_controller;

    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int AW   = 32;
    localparam int VW   = 16;
    localparam int TW   = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      go;
    logic [VW-1:0]             n_vec;
    logic [TW-1:0]             n_tiles;
    logic [AW-1:0]             w_base, w_stride, iact_base, iact_col_stride;
    logic [AW-1:0]             psum_base, psum_row_stride;
    logic                      mem_ready;
    logic [AW-1:0]             weight_addr;
    logic [COLS-1:0][AW-1:0]   iact_addr;
    logic [ROWS-1:0][AW-1:0]   psum_addr;
    logic                      load_weight;
    logic [COLS-1:0]           load_iact;
    logic [ROWS-1:0]           psum_valid;
    logic                      busy;
    logic                      done;

    ws_tile_controller #(
        .ARRAY_ROWS(ROWS), .ARRAY_COLS(COLS), .ADDR_W(AW), .VEC_W(VW), .TILE_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .n_vec(n_vec), .n_tiles(n_tiles),
        .w_base(w_base), .w_stride(w_stride), .iact_base(iact_base),
        .iact_col_stride(iact_col_stride), .psum_base(psum_base),
        .psum_row_stride(psum_row_stride), .mem_ready(mem_ready),
        .weight_addr(weight_addr), .iact_addr(iact_addr), .psum_addr(psum_addr),
        .load_weight(load_weight), .load_iact(load_iact), .psum_valid(psum_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nv;
        int          nt;
        logic [31:0] wb, ws, ib, ics, pb, prs;
        int          stall_cyc;
        int          stall_len;
        bit          go_spam;
        bit          pat_chk;
        int          exp_lat;
    } vec_t;

    vec_t        tbl[8];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] q_w[$];
    logic [31:0] q_i[COLS][$];
    logic [31:0] q_p[ROWS][$];
    logic [COLS-1:0] log_i[64];
    logic [ROWS-1:0] log_p[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe pops the oldest expected address on its channel.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] e;
            if (load_weight) begin
                if (q_w.size() == 0) chk("weight_extra_beat", 64'(load_weight), 64'd0);
                else begin e = q_w.pop_front(); chk("weight_addr", 64'(weight_addr), 64'(e)); end
            end
            for (int c = 0; c < COLS; c++) begin
                if (load_iact[c]) begin
                    if (q_i[c].size() == 0) chk($sformatf("iact%0d_extra_beat", c), 64'(load_iact[c]), 64'd0);
                    else begin e = q_i[c].pop_front(); chk($sformatf("iact%0d_addr", c), 64'(iact_addr[c]), 64'(e)); end
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                if (psum_valid[r]) begin
                    if (q_p[r].size() == 0) chk($sformatf("psum%0d_extra_beat", r), 64'(psum_valid[r]), 64'd0);
                    else begin e = q_p[r].pop_front(); chk($sformatf("psum%0d_addr", r), 64'(psum_addr[r]), 64'(e)); end
                end
            end
        end
    end

    task automatic flush_queues();
        q_w.delete();
        for (int c = 0; c < COLS; c++) q_i[c].delete();
        for (int r = 0; r < ROWS; r++) q_p[r].delete();
    endtask

    task automatic scramble_cfg();
        n_vec           = VW'($urandom);
        n_tiles         = TW'($urandom);
        w_base          = $urandom;
        w_stride        = $urandom;
        iact_base       = $urandom;
        iact_col_stride = $urandom;
        psum_base       = $urandom;
        psum_row_stride = $urandom;
    endtask

    // Skew pattern for n_vec=3 on a 3x3 array starting at cycle 4; stall inserted before k=2.
    task automatic check_pattern(input int stall_len);
        for (int k = 0; k < 8; k++) begin
            int              cyc;
            logic [COLS-1:0] ei;
            logic [ROWS-1:0] ep;
            cyc = 4 + k + ((k >= 2) ? stall_len : 0);
            ei  = '0;
            ep  = '0;
            for (int c = 0; c < COLS; c++) if (c <= k && k < c + 3) ei[c] = 1'b1;
            for (int r = 0; r < ROWS; r++) if (r + 3 <= k && k < r + 6) ep[r] = 1'b1;
            chk($sformatf("iact_pattern_k%0d", k), 64'(log_i[cyc]), 64'(ei));
            chk($sformatf("psum_pattern_k%0d", k), 64'(log_p[cyc]), 64'(ep));
        end
    endtask

    task automatic run_cfg(input vec_t v);
        int got_done = -1;
        int n_done   = 0;
        bit active;
        active = (v.nv != 0) && (v.nt != 0);
        if (active) begin
            for (int i = 0; i < v.nt * COLS; i++) q_w.push_back(v.wb + 32'(i) * v.ws);
            for (int t = 0; t < v.nt; t++) begin
                for (int j = 0; j < v.nv; j++) begin
                    for (int c = 0; c < COLS; c++) q_i[c].push_back(v.ib + 32'(c) * v.ics + 32'(j));
                    for (int r = 0; r < ROWS; r++)
                        q_p[r].push_back(v.pb + 32'(r) * v.prs + 32'(t * v.nv + j));
                end
            end
        end
        n_vec = VW'(v.nv); n_tiles = TW'(v.nt);
        w_base = v.wb; w_stride = v.ws; iact_base = v.ib; iact_col_stride = v.ics;
        psum_base = v.pb; psum_row_stride = v.prs;
        go = 1'b1;
        for (int cyc = 0; cyc < v.exp_lat + 8; cyc++) begin
            mem_ready = !(v.stall_len > 0 && cyc >= v.stall_cyc && cyc < v.stall_cyc + v.stall_len);
            @(negedge clk);
            if (cyc < 64) begin log_i[cyc] = load_iact; log_p[cyc] = psum_valid; end
            if (cyc == 0) chk("busy_at_go", 64'(busy), 64'd0);
            if (cyc == 1) chk("busy_after_go", 64'(busy), 64'd1);
            if (!mem_ready) chk("strobes_in_stall", 64'({load_weight, load_iact, psum_valid}), 64'd0);
            if (done) begin n_done++; if (got_done < 0) got_done = cyc; end
            @(posedge clk); #1;
            go = v.go_spam && (cyc + 1 <= v.exp_lat);
            scramble_cfg();
        end
        mem_ready = 1'b1;
        chk("done_cycle", 64'(got_done), 64'(v.exp_lat));
        chk("done_pulses", 64'(n_done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("weight_beats_left", 64'(q_w.size()), 64'd0);
        chk("iact0_beats_left", 64'(q_i[0].size()), 64'd0);
        chk("psum2_beats_left", 64'(q_p[ROWS-1].size()), 64'd0);
        if (active) begin
            chk("weight_addr_end", 64'(weight_addr), 64'(v.wb + 32'(v.nt * COLS) * v.ws));
            chk("iact_last_col_end", 64'(iact_addr[COLS-1]), 64'(v.ib + 32'(COLS-1) * v.ics));
            chk("psum0_end", 64'(psum_addr[0]), 64'(v.pb + 32'(v.nt * v.nv)));
            chk("psum_last_row_end", 64'(psum_addr[ROWS-1]),
                64'(v.pb + 32'(ROWS-1) * v.prs + 32'(v.nt * v.nv)));
        end
        if (v.pat_chk) check_pattern(v.stall_len);
        flush_queues();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            nv nt  wb        ws   ib        ics     pb        prs    stc sl spam pat lat
        tbl[0] = '{3, 1, 32'h0,    32'd1, 32'h0,    32'd1,   32'h0,    32'd1,   0, 0, 1'b0, 1'b1, 13};
        tbl[1] = '{3, 2, 32'h100,  32'd4, 32'h0,    32'd1,   32'h0,    32'd1,   0, 0, 1'b0, 1'b0, 25};
        tbl[2] = '{3, 1, 32'h0,    32'd1, 32'h0,    32'd1,   32'h0,    32'd1,   6, 2, 1'b0, 1'b1, 15};
        tbl[3] = '{0, 2, 32'h40,   32'd1, 32'h80,   32'd1,   32'hC0,   32'd1,   0, 0, 1'b0, 1'b0, 1};
        tbl[4] = '{4, 0, 32'h40,   32'd1, 32'h80,   32'd1,   32'hC0,   32'd1,   0, 0, 1'b0, 1'b0, 1};
        tbl[5] = '{1, 3, 32'h2000, 32'd8, 32'h400,  32'h40,  32'h800,  32'h20,  0, 0, 1'b0, 1'b0, 31};
        tbl[6] = '{5, 1, 32'h10,   32'd2, 32'h3000, 32'h100, 32'h5000, 32'h10,  9, 3, 1'b1, 1'b0, 18};
        tbl[7] = '{2, 2, 32'h0,    32'd3, 32'h70,   32'h8,   32'h900,  32'h100, 2, 1, 1'b0, 1'b0, 24};

        rst = 1'b1; go = 1'b0; mem_ready = 1'b1;
        scramble_cfg();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_strobes", 64'({load_weight, load_iact, psum_valid}), 64'd0);
        chk("reset_weight_addr", 64'(weight_addr), 64'd0);
        chk("reset_iact_addr", 64'(iact_addr[COLS-1]), 64'd0);
        chk("reset_psum_addr", 64'(psum_addr[ROWS-1]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) run_cfg(tbl[i]);

        // Reset in the middle of COMPUTE, then a clean run from fresh bases.
        mon_en = 1'b0;
        n_vec = 16'd3; n_tiles = 8'd1; w_base = 32'h0; w_stride = 32'd1;
        iact_base = 32'h0; iact_col_stride = 32'd1; psum_base = 32'h0; psum_row_stride = 32'd1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pre_reset_iact", 64'(load_iact), 64'(3'b111));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_reset_busy", 64'(busy), 64'd0);
        chk("midrun_reset_strobes", 64'({load_weight, load_iact, psum_valid, done}), 64'd0);
        chk("midrun_reset_addrs", 64'(weight_addr | iact_addr[0] | psum_addr[0]), 64'd0);
        @(posedge clk); #1;
        flush_queues();
        mon_en = 1'b1;
        run_cfg(tbl[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ws_tile_controller.md
Name: ws_tile_controller

Overview:
Sequencer for the weight-stationary PE array, generalised over the fixed 3x3 single-pass controller. Accepts runtime iact vector count, weight-tile count, base addresses and strides. Loops load-weights/compute per tile and generates per-column iact and per-row psum strobes and addresses. Honours a memory-ready stall. Sits between the top-level command interface and the block-RAM ports of the array.

Parameters:
ARRAY_ROWS, 3, PE rows (psum outputs)
ARRAY_COLS, 3, PE columns (iact inputs / weight beats per tile)
ADDR_W, 32, width of every address output and base/stride input
VEC_W, 16, width of n_vec and internal compute counter
TILE_W, 8, width of n_tiles and tile index

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
go  in  1  start pulse; sampled only in IDLE
n_vec  in  VEC_W  iact vectors streamed per tile
n_tiles  in  TILE_W  weight tiles to process
w_base  in  ADDR_W  first weight address
w_stride  in  ADDR_W  weight address increment per accepted beat
iact_base  in  ADDR_W  column-0 iact start address
iact_col_stride  in  ADDR_W  start-address offset between iact columns
psum_base  in  ADDR_W  row-0 psum start address
psum_row_stride  in  ADDR_W  start-address offset between psum rows
mem_ready  in  1  memory can accept a beat this cycle; 0 = stall
weight_addr  out  ADDR_W  weight read address
iact_addr  out  ARRAY_COLS x ADDR_W  per-column iact read address
psum_addr  out  ARRAY_ROWS x ADDR_W  per-row psum write address
load_weight  out  1  weight beat strobe
load_iact  out  ARRAY_COLS  per-column iact strobe
psum_valid  out  ARRAY_ROWS  per-row psum store strobe
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=1 at clk edge, any state): state=IDLE; all strobes, done and busy =0; all addresses and counters =0.
- States: IDLE, LOAD_W, COMPUTE, NEXT_TILE, DONE.
- IDLE: on go, latch all config inputs.
  - If n_vec==0 or n_tiles==0, go to DONE.
  - Otherwise go to LOAD_W, with weight_addr=w_base, iact_addr[c]=iact_base+c*iact_col_stride, psum_addr[r]=psum_base+r*psum_row_stride, and tile=0.
- go while busy is ignored. Config inputs are don't-care after latching.
- LOAD_W: load_weight=mem_ready.
  - Each cycle with mem_ready=1: beat counter +1 and weight_addr += w_stride.
  - After ARRAY_COLS accepted beats, go to COMPUTE with counter k=0.
  - weight_addr is not reset between tiles; tiles are contiguous.
- COMPUTE, with counter k:
  - load_iact[c] = mem_ready && (c <= k < c+n_vec).
  - psum_valid[r] = mem_ready && (r+ARRAY_COLS <= k < r+ARRAY_COLS+n_vec).
  - Each asserted strobe post-increments its own address by 1 on that edge.
  - k advances only when mem_ready=1. A stall freezes k, addresses and state, and deasserts all strobes.
  - Last k = n_vec+ARRAY_ROWS+ARRAY_COLS-2. When that k is accepted, go to NEXT_TILE.
  - Comparisons use VEC_W+1 bit arithmetic; no overflow for n_vec up to 2^VEC_W-1.
- NEXT_TILE: one cycle, no strobes.
  - tile += 1.
  - iact_addr[c] is reloaded to its start value; iacts are reused per tile.
  - psum_addr is not reloaded; tile outputs are appended per row.
  - If the incremented tile == n_tiles, go to DONE; else go to LOAD_W.
- DONE: done=1 for exactly one cycle, then IDLE. Addresses hold their last value until the next go.
- Latency with no stall: go at cycle 0 gives done at cycle 1 + n_tiles*(ARRAY_COLS + n_vec+ARRAY_ROWS+ARRAY_COLS-1 + 1).
- All outputs are decoded from registered state, counter and mem_ready; there is no combinational path from go to any output.

Test Plan:
- ROWS=COLS=3, n_vec=3, n_tiles=1, bases 0, strides 1, mem_ready=1, go at cycle 0:
  - load_weight cycles 1-3, weight_addr 0,1,2.
  - load_iact patterns 100,110,111,011,001 at cycles 4-8.
  - psum_valid 100,110,111,011,001 at cycles 7-11.
  - done at cycle 13.
- Same config, n_tiles=2, w_base=0x100, w_stride=4:
  - Second LOAD_W addresses 0x10C,0x110,0x114.
  - iact_addr[0] restarts at 0 for tile 2.
  - psum_addr[0] ends at 6.
  - Exactly one done pulse.
- mem_ready=0 for 2 cycles at COMPUTE k=2:
  - Strobes 0 during the stall; k and addresses held.
  - k=2 pattern 111 re-emitted afterwards.
  - done delayed by 2 cycles.
- n_vec=0 or n_tiles=0 with go → IDLE, DONE, IDLE; done pulses once; no strobe asserted.
- rst asserted mid-COMPUTE → next cycle IDLE, all outputs 0, busy=0. A subsequent go runs normally from the base addresses.
- go pulsed repeatedly while busy → no restart and no config change; the run completes with the originally latched n_vec.
